// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one 8-bit ALU. Each 16-bit operation runs as a
// low-byte pass and then a high-byte pass, with the carry chained between them.
module alu_share_arbiter #(
  parameter bit RR_RESET_LAST = 1'b1
) (
  input  logic        IN_clk,
  input  logic        IN_rst,
  input  logic        IN_req0,
  input  logic [3:0]  IN_op0,
  input  logic [15:0] IN_a0,
  input  logic [15:0] IN_b0,
  input  logic        IN_req1,
  input  logic [3:0]  IN_op1,
  input  logic [15:0] IN_a1,
  input  logic [15:0] IN_b1,
  output logic        OUT_ack0,
  output logic        OUT_ack1,
  output logic [15:0] OUT_result,
  output logic        OUT_carry,
  output logic        OUT_zero,
  output logic        OUT_less_than,
  output logic        OUT_busy,
  output logic [1:0]  OUT_grant,
  output logic [7:0]  OUT_data_a,
  output logic [7:0]  OUT_data_b,
  output logic [3:0]  OUT_ALU_OP,
  output logic        OUT_carry_out,
  input  logic [7:0]  IN_S,
  input  logic        IN_carry_in,
  input  logic        IN_zero
);
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  localparam logic [3:0] OP_ADD = 4'hA, OP_SUB = 4'hB, OP_CMP = 4'hE;

  state_t      r_state, w_next;
  logic        r_last;
  logic [3:0]  r_op;
  logic [7:0]  r_a_hi, r_b_hi, r_res_lo;
  logic        r_lo_zero;

  logic        w_gnt_vld, w_gnt_port;
  logic [3:0]  w_op;
  logic [15:0] w_a, w_b;

  function automatic logic valid_op(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  function automatic logic [3:0] alu_op(input logic [3:0] op);
    return valid_op(op) ? op : 4'h0;
  endfunction

  // Under contention the port that was not served last wins.
  always_comb begin
    w_gnt_vld  = IN_req0 | IN_req1;
    w_gnt_port = (IN_req0 & IN_req1) ? ~r_last : IN_req1;
    w_op       = w_gnt_port ? IN_op1 : IN_op0;
    w_a        = w_gnt_port ? IN_a1  : IN_a0;
    w_b        = w_gnt_port ? IN_b1  : IN_b0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_next = S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      r_last        <= RR_RESET_LAST;
      r_op          <= '0;
      r_a_hi        <= '0;
      r_b_hi        <= '0;
      r_res_lo      <= '0;
      r_lo_zero     <= 1'b0;
      OUT_ack0      <= 1'b0;
      OUT_ack1      <= 1'b0;
      OUT_result    <= '0;
      OUT_carry     <= 1'b0;
      OUT_zero      <= 1'b0;
      OUT_less_than <= 1'b0;
      OUT_busy      <= 1'b0;
      OUT_grant     <= '0;
      OUT_data_a    <= '0;
      OUT_data_b    <= '0;
      OUT_ALU_OP    <= '0;
      OUT_carry_out <= 1'b0;
    end else begin
      OUT_ack0 <= 1'b0;
      OUT_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_op          <= w_op;
            r_a_hi        <= w_a[15:8];
            r_b_hi        <= w_b[15:8];
            r_last        <= w_gnt_port;
            OUT_grant     <= w_gnt_port ? 2'b10 : 2'b01;
            OUT_busy      <= 1'b1;
            OUT_data_a    <= w_a[7:0];
            OUT_data_b    <= w_b[7:0];
            OUT_ALU_OP    <= alu_op(w_op);
            OUT_carry_out <= (w_op == OP_SUB) || (w_op == OP_CMP);
          end else begin
            OUT_data_a    <= '0;
            OUT_data_b    <= '0;
            OUT_ALU_OP    <= '0;
            OUT_carry_out <= 1'b0;
          end
        end
        S_LO: begin
          r_res_lo      <= IN_S;
          r_lo_zero     <= IN_zero;
          OUT_data_a    <= r_a_hi;
          OUT_data_b    <= r_b_hi;
          // Logic ops and invalid opcodes never chain a carry.
          OUT_carry_out <= ((r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_CMP))
                           ? IN_carry_in : 1'b0;
        end
        S_HI: begin
          if (valid_op(r_op)) begin
            OUT_result    <= {IN_S, r_res_lo};
            OUT_carry     <= IN_carry_in;
            OUT_zero      <= r_lo_zero & IN_zero;
            OUT_less_than <= (r_op == OP_CMP) & ~IN_carry_in;
          end else begin
            OUT_result    <= '0;
            OUT_carry     <= 1'b0;
            OUT_zero      <= 1'b1;
            OUT_less_than <= 1'b0;
          end
          OUT_ack0      <= OUT_grant[0];
          OUT_ack1      <= OUT_grant[1];
          OUT_busy      <= 1'b0;
          OUT_grant     <= '0;
          OUT_data_a    <= '0;
          OUT_data_b    <= '0;
          OUT_ALU_OP    <= '0;
          OUT_carry_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: byte ALU model, vector table, random ops
// against a 16-bit arithmetic reference, and contention/reset sequences.
module tb_alu_share_arbiter;
  logic        clk = 1'b0, rst;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1, carry, zero, lt, busy, cout;
  logic [15:0] result;
  logic [1:0]  grant;
  logic [7:0]  da, db, alu_s;
  logic [3:0]  aop;
  logic        alu_c, alu_z;
  logic [8:0]  alu_t;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .IN_clk(clk), .IN_rst(rst),
    .IN_req0(req0), .IN_op0(op0), .IN_a0(a0), .IN_b0(b0),
    .IN_req1(req1), .IN_op1(op1), .IN_a1(a1), .IN_b1(b1),
    .OUT_ack0(ack0), .OUT_ack1(ack1), .OUT_result(result),
    .OUT_carry(carry), .OUT_zero(zero), .OUT_less_than(lt),
    .OUT_busy(busy), .OUT_grant(grant),
    .OUT_data_a(da), .OUT_data_b(db), .OUT_ALU_OP(aop), .OUT_carry_out(cout),
    .IN_S(alu_s), .IN_carry_in(alu_c), .IN_zero(alu_z)
  );

  // The shared 8-bit ALU the arbiter drives.
  always_comb begin
    alu_t = '0;
    case (aop)
      4'hA:       alu_t = {1'b0, da} + {1'b0, db} + {8'h0, cout};
      4'hB, 4'hE: alu_t = {1'b0, da} + {1'b0, ~db} + {8'h0, cout};
      4'hC:       alu_t = {1'b0, da & db};
      4'hD:       alu_t = {1'b0, da | db};
      default:    alu_t = '0;
    endcase
    alu_s = alu_t[7:0];
    alu_c = alu_t[8];
    alu_z = (alu_t[7:0] == 8'h0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // 16-bit reference: what the whole two-pass operation should produce.
  task automatic ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic c, output logic z, output logic l);
    logic [16:0] s;
    r = '0; c = 1'b0; l = 1'b0;
    case (op)
      4'hA: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      4'hB, 4'hE: begin r = a - b; c = (a >= b); l = (op == 4'hE) && (a < b); end
      4'hC: r = a & b;
      4'hD: r = a | b;
      default: r = '0;
    endcase
    z = (r == 16'h0);
  endtask

  task automatic run_op(input bit port, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ec,
                        input logic ez, input logic el, input string nm);
    int cyc;
    @(negedge clk);
    if (port) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else      begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    @(posedge clk);
    @(negedge clk);
    // Drop the request and scramble operands: the latched copy must be used.
    req0 = 0; req1 = 0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 4'h0; op1 = 4'h0;
    chk({nm, "_grant"}, {busy, grant}, {1'b1, port ? 2'b10 : 2'b01});
    cyc = 1;
    while (!(port ? ack1 : ack0) && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk({nm, "_grant_hi"}, grant, port ? 2'b10 : 2'b01);
    end
    chk({nm, "_latency"}, cyc, 3);
    chk({nm, "_res"}, {result, carry, zero, lt}, {er, ec, ez, el});
    chk({nm, "_other"}, {(port ? ack0 : ack1), busy, grant}, 0);
  endtask

  typedef struct {
    bit         port;
    logic [3:0] op;
    logic [15:0] a, b, r;
    logic       c, z, l;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [63:0] all_outs();
    return {ack0, ack1, result, carry, zero, lt, busy, grant, da, db, aop, cout};
  endfunction

  initial begin
    logic [15:0] ra, rb, er;
    logic [3:0]  rop;
    logic        ec, ez, el, rp;
    int          nack, cyc;
    logic [15:0] ores [2];

    tbl[0] = '{0, 4'hA, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0};
    tbl[1] = '{0, 4'hB, 16'h0100, 16'h0001, 16'h00FF, 1, 0, 0};
    tbl[2] = '{0, 4'hA, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0};
    tbl[3] = '{0, 4'hE, 16'h0005, 16'h0010, 16'hFFF5, 0, 0, 1};
    tbl[4] = '{1, 4'hE, 16'h1234, 16'h1234, 16'h0000, 1, 1, 0};
    tbl[5] = '{1, 4'hC, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0};
    tbl[6] = '{0, 4'hD, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0};
    tbl[7] = '{1, 4'h7, 16'h1234, 16'h4321, 16'h0000, 0, 1, 0};
    tbl[8] = '{1, 4'hA, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 0};
    tbl[9] = '{0, 4'hB, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0};

    rst = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst = 0;

    foreach (tbl[i])
      run_op(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].z,
             tbl[i].l, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rp  = 1'($urandom);
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(10, 14));
      ra  = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
      rb  = (i % 5 == 0) ? ra : 16'($urandom);
      ref_op(rop, ra, rb, er, ec, ez, el);
      run_op(rp, rop, ra, rb, er, ec, ez, el, $sformatf("rnd%0d", i));
    end

    // Contention right after reset: grants alternate starting with port 0.
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    req0 = 1; op0 = 4'hD; a0 = 16'h0F00; b0 = 16'h00F0;
    req1 = 1; op1 = 4'hC; a1 = 16'hF0F0; b1 = 16'h0FF0;
    ores[0] = 16'h0FF0; ores[1] = 16'h00F0;
    nack = 0; cyc = 0;
    while (nack < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ack0 && ack1) chk("ack_coincide", 1, 0);
      else if (ack0 || ack1) begin
        chk($sformatf("alt_port%0d", nack), ack1, nack % 2);
        chk($sformatf("alt_res%0d", nack), result, ores[ack1]);
        nack++;
      end
    end
    chk("alt_count", nack, 4);
    req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);

    // Reset in LO aborts without an ack and clears outputs asynchronously.
    req0 = 1; op0 = 4'hA; a0 = 16'h00FF; b0 = 16'h0001;
    @(posedge clk); @(negedge clk);
    req0 = 0;
    chk("midop_busy", {busy, grant}, 3'b101);
    #1 rst = 1;
    #1 chk("midop_async", all_outs(), 0);
    nack = 0;
    repeat (4) begin @(negedge clk); if (ack0 || ack1) nack++; end
    rst = 0;
    repeat (3) begin @(negedge clk); if (ack0 || ack1) nack++; end
    chk("midop_noack", nack, 0);
    req0 = 1; req1 = 1;
    @(posedge clk); @(negedge clk);
    req0 = 0; req1 = 0;
    chk("post_rst_grant", grant, 2'b01);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters: port 0 is the calculator core, port 1 is the music/tone unit.
- Accepts 16-bit operations from either port and runs each as two byte passes through the ALU, low byte first, then high byte with carry chained.
- Returns a 16-bit result, flags and a one-cycle acknowledge to the granted port.
- Sits between both requesters and the ALU and is the only block that drives ALU inputs.

Parameters:
- RR_RESET_LAST, 1, port index treated as "last granted" after reset; default 1 means port 0 wins the first contention.

Ports:
- IN_clk  input  1  system clock, rising edge
- IN_rst  input  1  asynchronous reset, active-high
- IN_req0  input  1  port 0 request, level
- IN_op0  input  4  port 0 opcode: A add, B sub, C and, D or, E cmp
- IN_a0  input  16  port 0 operand A
- IN_b0  input  16  port 0 operand B
- IN_req1  input  1  port 1 request, level
- IN_op1  input  4  port 1 opcode
- IN_a1  input  16  port 1 operand A
- IN_b1  input  16  port 1 operand B
- OUT_ack0  output  1  one-cycle pulse: port 0 result valid
- OUT_ack1  output  1  one-cycle pulse: port 1 result valid
- OUT_result  output  16  result of the last completed operation
- OUT_carry  output  1  high-byte carry out
- OUT_zero  output  1  16-bit result is zero
- OUT_less_than  output  1  unsigned A<B, valid for cmp
- OUT_busy  output  1  operation in flight
- OUT_grant  output  2  one-hot owner of the current operation; 00 when idle
- OUT_data_a  output  8  ALU operand A byte
- OUT_data_b  output  8  ALU operand B byte
- OUT_ALU_OP  output  4  ALU opcode
- OUT_carry_out  output  1  carry into the ALU
- IN_S  input  8  ALU result byte, combinational from the registered ALU inputs
- IN_carry_in  input  1  ALU carry out
- IN_zero  input  1  ALU byte-zero flag

Behaviour:
- Reset: IN_rst=1 forces all of the following, asynchronously:
  - state IDLE;
  - every output 0, including OUT_result, all flags, OUT_grant, the acks and all ALU drive;
  - last-grant pointer = RR_RESET_LAST.
- ALU opcode and carry rules:
  - B and E: ALU computes a + ~b + cin.
  - A: low-byte cin=0.
  - B and E: low-byte cin=1.
  - C and D: cin=0 on both bytes.
  - High-byte cin = carry captured from the low-byte pass.
- State IDLE:
  - If any request is high, grant the requester.
  - If both are high, grant the port that is not the last-granted one.
  - On grant:
    - latch op, A and B for the granted port;
    - update the pointer;
    - set OUT_grant and OUT_busy=1;
    - drive A[7:0], B[7:0], op and low cin;
    - go to LO.
  - No request: ALU drive is 0.
- State LO (ALU evaluating low byte):
  - Capture IN_S into res[7:0], and capture IN_carry_in and IN_zero.
  - Drive A[15:8], B[15:8], op and the chained cin.
  - Go to HI.
- State HI:
  - Capture IN_S into res[15:8].
  - Update outputs:
    - OUT_result = res;
    - OUT_carry = high-byte carry;
    - OUT_zero = lo_zero AND hi_zero;
    - OUT_less_than = ~hi_carry for E, otherwise 0.
  - Pulse the granted ack for this cycle.
  - Clear OUT_busy, OUT_grant and ALU drive.
  - Go to IDLE.
- Latency and throughput:
  - Request sampled at edge N gives ack high for the cycle after edge N+2.
  - OUT_result, flags and ack update on the same edge.
  - Result and flags hold until the next completion.
- Cmp (E): OUT_result carries A-B as a two's-complement value; OUT_less_than is the primary output.
- Invalid opcode (0-9, F):
  - The sequence runs normally with OUT_ALU_OP=0.
  - Completion forces result=0, OUT_zero=1, carry=0 and less_than=0, and the ack still pulses.
- Request protocol:
  - Operands are latched at grant, so the requester may change them or drop req afterwards.
  - A dropped request still completes and still acks.
  - req held high after ack is a new request and is arbitrated in the following IDLE cycle.
- Fairness:
  - After a port-0 completion with both requesting, port 1 is granted next.
  - Alternation continues while both stay high.
  - Neither port waits more than one operation.
- Requests during LO/HI are ignored; no queueing.
- Reset mid-operation aborts immediately:
  - no ack is produced for the aborted operation;
  - result and flags go to 0.
- Wrap-around: add overflow past 0xFFFF gives the 16-bit sum with OUT_carry=1.

Test Plan:
- Add with carry chain: port 0 alone, op A, 0x00FF+0x0001 → ack0 three cycles after req; OUT_result=0x0100, carry=0, zero=0, OUT_grant=01 during LO/HI.
- Sub and overflow:
  - op B, 0x0100-0x0001 → 0x00FF, carry=1.
  - op A, 0xFFFF+0x0001 → 0x0000, carry=1, zero=1.
- Compare: op E, 0x0005 vs 0x0010 → less_than=1, result 0xFFF5; op E, 0x1234 vs 0x1234 → less_than=0, zero=1.
- Contention after reset: req0 and req1 asserted in the same cycle and held → grants alternate 0,1,0,1; ack0 and ack1 never coincide; port 1 op C 0xF0F0&0x0FF0 → 0x00F0; port 0 op D 0x0F00|0x00F0 → 0x0FF0.
- Reset mid-operation:
  - IN_rst asserted while in LO → all outputs 0 with no clock edge needed; no ack follows.
  - After release, a simultaneous request grants port 0.
- Invalid opcode and dropped request:
  - op 7 → ack with result 0, zero=1.
  - req1 dropped one cycle after grant → ack1 still pulses with the correct result.
